apb_master_arbiter: RTL and testbench



---
 rtl/apb_master_arbiter.sv | 147 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Two-requester APB master. Requester 0 (internal command source) and
//   requester 1 (interrupt-service / DMA engine) share one APB bus through a
//   round-robin arbiter. The block sequences SETUP/ACCESS, aborts a transfer
//   whose slave holds PREADY low for TIMEOUT ACCESS cycles, and returns read
//   data and error status to the requester that issued the command.
//
// Ports
//   PCLK, PRESET              clock, asynchronous active-high reset
//   rN_valid/rN_ready         command handshake, requester N (N = 0,1)
//   rN_write/rN_addr/rN_wdata command payload, held stable until ready
//   rN_rsp_valid              one-cycle response pulse to requester N
//   rsp_rdata, rsp_err        response payload, valid with rN_rsp_valid
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB master outputs
//   PRDATA/PREADY/PSLVERR              APB slave response
`ifndef APB_ADDR_WIDTH
  `define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
  `define APB_DATA_WIDTH 32
`endif

module apb_master_arbiter #(
  parameter int ADDR_W  = `APB_ADDR_WIDTH,
  parameter int DATA_W  = `APB_DATA_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // requester 0
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  // requester 1
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  // shared response payload
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_grant;  // id of the most recently granted requester
  logic             cur_id;      // id of the requester owning the bus
  logic             grant0;
  logic             grant1;

  // Round-robin: r1 wins if it is alone, or if both ask and r0 went last.
  // Ready is masked by reset so no handshake is advertised while the
  // registers are being held clear.
  always_comb begin
    grant1   = r1_valid & (~r0_valid | ~last_grant);
    grant0   = r0_valid & ~grant1;
    r0_ready = (state == IDLE) & grant0 & ~PRESET;
    r1_ready = (state == IDLE) & grant1 & ~PRESET;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      // response pulses last exactly one cycle
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      case (state)
        // IDLE -> SETUP: latch the granted command onto the bus
        IDLE: begin
          if (r0_ready || r1_ready) begin
            PWRITE     <= grant1 ? r1_write : r0_write;
            PADDR      <= grant1 ? r1_addr  : r0_addr;
            PWDATA     <= grant1 ? r1_wdata : r0_wdata;
            cur_id     <= grant1;
            last_grant <= grant1;
            wait_cnt   <= '0;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            state      <= SETUP;
          end
        end
        // SETUP -> ACCESS
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        // ACCESS -> IDLE on PREADY or timeout; response goes out next cycle
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata    <= PWRITE ? '0 : PRDATA;
            rsp_err      <= PSLVERR;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            r0_rsp_valid <= ~cur_id;
            r1_rsp_valid <= cur_id;
            state        <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // this is the TIMEOUT-th cycle with PREADY low
            if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
              rsp_rdata    <= '0;
              rsp_err      <= 1'b1;
              PSEL         <= 1'b0;
              PENABLE      <= 1'b0;
              r0_rsp_valid <= ~cur_id;
              r1_rsp_valid <= cur_id;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter: requester drivers, a simple APB slave
// with programmable wait states / error / hang, and a response scoreboard.
module tb_apb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          r0_valid, r0_ready, r0_write, r0_rsp_valid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_valid, r1_ready, r1_write, r1_rsp_valid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  bit   grant_log[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // slave behaviour knobs
  int            slv_wait     = 0;
  bit            slv_hang     = 0;
  bit            slv_err      = 0;
  bit            slv_err_wait = 0;
  logic [DW-1:0] slv_rdata    = 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Call at a negedge. Returns at the negedge of cycle T+1 (T = handshake).
  task automatic issue(input bit id, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input bit expect_rsp);
    exp_t e;
    bit   got;
    got = 0;
    if (id) begin
      r1_valid = 1; r1_write = wr; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_valid = 1; r0_write = wr; r0_addr = addr; r0_wdata = wdata;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (id ? r1_ready : r0_ready) begin
        got = 1;
        grant_log.push_back(id);
        if (expect_rsp) begin
          e.id    = id;
          e.rdata = (wr || slv_hang) ? '0 : slv_rdata;
          e.err   = slv_hang ? 1'b1 : slv_err;
          sb.push_back(e);
        end
      end
      @(negedge PCLK);
    end
    if (!got) chk("ready_wait", 0, 1);
    if (id) r1_valid = 0; else r0_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge PCLK);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge PCLK);
  endtask

  // APB slave: PREADY decided each negedge of an ACCESS cycle
  initial begin
    int wcnt;
    wcnt = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (!slv_hang && wcnt >= slv_wait) PREADY = 1;
        else begin PREADY = 0; wcnt++; end
      end else begin
        PREADY = 0; wcnt = 0;
      end
      PSLVERR = PREADY ? slv_err : slv_err_wait;
      PRDATA  = slv_rdata;
    end
  end

  // response scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (r0_rsp_valid || r1_rsp_valid) begin
        chk("rsp_onehot", r0_rsp_valid & r1_rsp_valid, 0);
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", r1_rsp_valid, e.id);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  // ready must be one-hot and only while the bus is idle
  initial begin
    forever begin
      @(posedge PCLK);
      if (r0_ready || r1_ready) begin
        chk("ready_onehot", r0_ready & r1_ready, 0);
        chk("ready_in_idle", PSEL, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_alt[6];
    PRESET = 1;
    r0_valid = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp", {r0_rsp_valid, r1_rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    PRESET = 0;
    @(negedge PCLK);

    // tie out of reset, both held: r0,r1,r0,r1,r0,r1
    grant_log.delete();
    fork
      for (int k = 0; k < 3; k++) issue(0, 1, 32'h100 + k, 32'hA000 + k, 1);
      for (int k = 0; k < 3; k++) issue(1, 0, 32'h200 + k, '0, 1);
    join
    drain();
    exp_alt = '{0, 1, 0, 1, 0, 1};
    chk("alt_len", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("alt_order", grant_log[k], exp_alt[k]);

    // single write, zero wait
    issue(0, 1, 32'h010, 32'hA5A5_0001, 1);
    chk("wr_psel_t1", {PSEL, PENABLE}, 2'b10);
    chk("wr_paddr", PADDR, 32'h010);
    chk("wr_pwdata", PWDATA, 32'hA5A5_0001);
    chk("wr_pwrite", PWRITE, 1);
    @(negedge PCLK);
    chk("wr_penable_t2", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    chk("wr_rsp_t3", r0_rsp_valid, 1);
    chk("wr_idle_t3", {PSEL, PENABLE}, 2'b00);
    chk("wr_hold_paddr", PADDR, 32'h010);
    drain();

    // read, 3 wait states
    slv_wait = 3; slv_rdata = 32'h1234_5678;
    issue(1, 0, 32'h004, '0, 1);
    repeat (4) @(negedge PCLK);
    chk("rd_rsp_t5", r1_rsp_valid, 0);
    @(negedge PCLK);
    chk("rd_rsp_t6", r1_rsp_valid, 1);
    drain();

    // slave error with PREADY, and PSLVERR during waits ignored
    slv_wait = 2; slv_err = 1; slv_err_wait = 1;
    issue(1, 1, 32'h008, 32'h55, 1);
    drain();
    slv_err = 0;
    issue(0, 0, 32'h00C, '0, 1);
    drain();
    slv_err_wait = 0; slv_wait = 0;

    // timeout, then normal command
    slv_hang = 1; slv_rdata = 32'hCAFE_F00D;
    issue(0, 0, 32'h020, '0, 1);
    repeat (16) @(negedge PCLK);
    chk("to_psel_t17", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    chk("to_psel_t18", {PSEL, PENABLE}, 2'b00);
    chk("to_rsp_t18", r0_rsp_valid, 1);
    drain();
    slv_hang = 0;
    issue(1, 0, 32'h024, '0, 1);
    drain();

    // reset during ACCESS: bus freed at once, no response
    slv_hang = 1;
    issue(0, 1, 32'h030, 32'h77, 0);
    repeat (3) @(negedge PCLK);
    #2 PRESET = 1;
    #1;
    chk("mrst_psel", {PSEL, PENABLE}, 2'b00);
    chk("mrst_payload", {PWRITE, PADDR, PWDATA}, 0);
    chk("mrst_rsp", {r0_rsp_valid, r1_rsp_valid, rsp_err}, 0);
    @(negedge PCLK);
    PRESET = 0; slv_hang = 0;
    grant_log.delete();
    fork
      issue(0, 1, 32'h040, 32'h1, 1);
      issue(1, 1, 32'h044, 32'h2, 1);
    join
    drain();
    chk("post_rst_len", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("post_rst_first", grant_log[0], 0);
      chk("post_rst_second", grant_log[1], 1);
    end

    repeat (5) @(negedge PCLK);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
